dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 4096, memory size in 32-bit words (power of two).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, first byte address served.
REQ-003 Parameter WAIT_CYCLES, default 0, extra wait states inserted before each response (0..15).
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 mem_in  input  mem_in_type  request from initiator:
- mem_valid (1)
- mem_instr (1)
- mem_addr (32)
- mem_wdata (32)
- mem_wstrb (4)
REQ-007 mem_out  output  mem_out_type  response:
- mem_ready (1)
- mem_rdata (32)
REQ-008 mem_err  output  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH), valid only with mem_ready.

Function
REQ-009 FSM states are IDLE, WAIT and RESP.
REQ-010 IDLE with mem_valid=1 accepts the request: latch addr, wdata, wstrb and instr; load the wait counter with WAIT_CYCLES.
- WAIT_CYCLES=0: go to RESP.
- Otherwise: go to WAIT.
REQ-011 WAIT decrements the counter each cycle and goes to RESP on the edge where the counter reaches 0.
REQ-012 RESP drives mem_ready=1 for exactly one cycle, then returns to IDLE unconditionally.
REQ-013 Latency: a request accepted in cycle N sees mem_ready=1 in cycle N+1+WAIT_CYCLES.
REQ-014 Throughput: at most one request per WAIT_CYCLES+2 cycles.
REQ-015 mem_valid is ignored in WAIT and RESP; a request still asserted during RESP is accepted as a new request in the following IDLE cycle.
REQ-016 The initiator holds all request fields stable until mem_ready; only the values latched at acceptance are used.
REQ-017 Word index = (mem_addr - BASE_ADDR) >> 2; mem_addr[1:0] is ignored, since alignment is checked upstream.
REQ-018 mem_wstrb=0 denotes a read: the addressed word is placed on mem_rdata during RESP.
REQ-019 mem_wstrb!=0 denotes a write:
- byte lane i is written with mem_wdata[8i+7:8i] only when mem_wstrb[i]=1; other lanes are preserved;
- the write takes effect on the edge entering RESP;
- mem_rdata=0 during a write response.
REQ-020 A read issued immediately after a write to the same word returns the merged new value.
REQ-021 Out-of-range access:
- respond with normal timing, mem_ready=1, mem_err=1, mem_rdata=0;
- a write is discarded and memory is unchanged.
REQ-022 Outside RESP: mem_ready=0, mem_err=0, mem_rdata=0.
REQ-023 mem_instr is latched but does not change behaviour.

Reset
REQ-024 rst=0 forces, asynchronously and immediately, state=IDLE, counter=0, mem_ready=0, mem_err=0, mem_rdata=0, latched request=0.
REQ-025 Reset during WAIT or RESP aborts the transaction: no response is issued, and a pending write not yet committed is dropped.
REQ-026 Memory array contents are not cleared by reset.
REQ-027 After rst rises, the first request is acceptable in the first clk cycle.

Structure
REQ-028 mem_in_type and mem_out_type live in the shared wires package; the FSM state enum and the default WAIT_CYCLES constant live in constants.
REQ-029 The storage is a separate sub-module, dmem_ram:
- DEPTH x 32 with per-byte write enable;
- synchronous read, with read data registered on the same edge as the write.
REQ-030 dmem_responder contains the FSM, wait counter, range check and output registers only.

Verification
REQ-031 WAIT_CYCLES=0: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then read 0x10.
- mem_ready 1 cycle after each acceptance;
- read returns 0xDEADBEEF, mem_err=0.
REQ-032 Byte strobes: after REQ-031, write 0x10 with wdata 0x00AA0000, wstrb 4'b0100, then read 0x10 -> 0xDEAABEEF.
REQ-033 WAIT_CYCLES=3: read accepted in cycle 5 -> mem_ready=1 only in cycle 9.
- mem_valid held through cycle 9 -> next acceptance in cycle 10.
REQ-034 Out of range with DEPTH=4096, BASE 0: write addr 0x4000 with wdata 0x12345678, then read 0x4000.
- both get mem_ready=1, mem_err=1, rdata=0;
- memory word 0 is unchanged.
REQ-035 Reset: assert rst=0 mid-WAIT of a write to 0x20 -> outputs 0 immediately, no mem_ready; a later read of 0x20 returns its old value.
REQ-036 Back-to-back: 8 consecutive reads with mem_valid held high -> exactly 8 single-cycle mem_ready pulses, WAIT_CYCLES+2 cycles apart.

Source files
------------

// File: rtl/constants.sv
// Shared constants: responder FSM encoding and default wait-state count.
package constants;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int WAIT_CYCLES_DEFAULT = 0;

endpackage

// File: rtl/wires.sv
// Signal bundles exchanged between the core's memory initiator and
// the data-memory responder.
package wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM with byte write enables.
// Read data is registered on the same edge that commits a write.
module dmem_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES,
// then answers with a single-cycle mem_ready pulse.
module dmem_responder
    import wires::*;
    import constants::*;
#(
    parameter int          DEPTH       = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        rst,
    input  logic        clk,
    input  mem_in_type  mem_in,
    output mem_out_type mem_out,
    output logic        mem_err
);

    localparam int AW = $clog2(DEPTH);

    state_t      state;
    state_t      next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    mem_in_type  req_q;
    mem_in_type  src;
    logic        accept;
    logic        in_range;
    logic        ram_en;
    logic [31:0] offset;
    logic [31:0] ram_rdata;
    logic        unused_ok;

    assign accept = (state == IDLE) && mem_in.mem_valid;

    // On a zero-wait accept the RAM is hit before req_q has loaded.
    assign src      = accept ? mem_in : req_q;
    assign offset   = src.mem_addr - BASE_ADDR;
    assign in_range = (src.mem_addr >= BASE_ADDR)
                   && ((offset >> 2) < 32'(DEPTH));

    always_comb begin
        next     = state;
        cnt_next = cnt;
        unique case (state)
            IDLE: begin
                if (mem_in.mem_valid) begin
                    cnt_next = 4'(WAIT_CYCLES);
                    next     = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    next = RESP;
                end
            end
            RESP: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            state <= next;
            cnt   <= cnt_next;
            if (accept) begin
                req_q <= mem_in;
            end
        end
    end

    assign ram_en = (next == RESP) && (state != RESP) && in_range;

    dmem_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (src.mem_wstrb & {4{ram_en}}),
        .addr (offset[AW+1:2]),
        .wdata(src.mem_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        mem_out = '0;
        mem_err = 1'b0;
        if (state == RESP) begin
            mem_out.mem_ready = 1'b1;
            mem_err           = !in_range;
            if (in_range && (req_q.mem_wstrb == 4'h0)) begin
                mem_out.mem_rdata = ram_rdata;
            end
        end
    end

    assign unused_ok = ^{src.mem_instr, src.mem_valid, offset};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: zero-wait and three-wait instances
// share clock and reset.
module tb_dmem_responder;
    import wires::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    mem_in_type  in0;
    mem_in_type  in3;
    mem_out_type out0;
    mem_out_type out3;
    logic        err0;
    logic        err3;
    int          vecs = 0;
    int          errs = 0;
    int          cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(
        .DEPTH(4096), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)
    ) dut0 (
        .rst(rst), .clk(clk), .mem_in(in0), .mem_out(out0), .mem_err(err0)
    );

    dmem_responder #(
        .DEPTH(4096), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)
    ) dut3 (
        .rst(rst), .clk(clk), .mem_in(in3), .mem_out(out3), .mem_err(err3)
    );

    function automatic logic rdy(input int sel);
        return (sel == 3) ? out3.mem_ready : out0.mem_ready;
    endfunction

    function automatic logic [31:0] rd(input int sel);
        return (sel == 3) ? out3.mem_rdata : out0.mem_rdata;
    endfunction

    function automatic logic er(input int sel);
        return (sel == 3) ? err3 : err0;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        mem_in_type r;
        r.mem_valid = v;
        r.mem_instr = 1'b0;
        r.mem_addr  = a;
        r.mem_wdata = d;
        r.mem_wstrb = s;
        if (sel == 3) in3 = r;
        else in0 = r;
    endtask

    // One request; returns edges-to-ready (-1 on timeout) and response.
    task automatic xact(input int sel, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int lat, output logic [31:0] rdata,
                        output logic err);
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        drive(sel, 1'b1, a, d, s);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rdy(sel)) begin
                lat   = k;
                rdata = rd(sel);
                err   = er(sel);
                break;
            end
        end
        drive(sel, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(3, 1'b0, 32'h0, 32'h0, 4'h0);
        #3;
        vecs++;
        if (out0 !== '0 || err0 !== 1'b0) begin
            errs++;
            $display("FAIL rst_out0 got %h/%b want 0/0", out0, err0);
        end
        vecs++;
        if (out3 !== '0 || err3 !== 1'b0) begin
            errs++;
            $display("FAIL rst_out3 got %h/%b want 0/0", out3, err3);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_write_read;
        int lat; logic [31:0] r; logic e;
        xact(0, 32'h10, 32'hDEADBEEF, 4'hF, lat, r, e);
        vecs++;
        if (lat !== 1 || e !== 1'b0 || r !== 32'h0) begin
            errs++;
            $display("FAIL wr10 got lat=%0d err=%b rdata=%h want 1/0/0", lat, e, r);
        end
        xact(0, 32'h10, 32'h0, 4'h0, lat, r, e);
        vecs++;
        if (lat !== 1 || e !== 1'b0 || r !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL rd10 got lat=%0d err=%b rdata=%h want 1/0/deadbeef", lat, e, r);
        end
    endtask

    task automatic test_strobe;
        int lat; logic [31:0] r; logic e;
        xact(0, 32'h10, 32'h00AA0000, 4'b0100, lat, r, e);
        vecs++;
        if (lat !== 1 || r !== 32'h0) begin
            errs++;
            $display("FAIL strb_wr got lat=%0d rdata=%h want 1/0", lat, r);
        end
        xact(0, 32'h10, 32'h0, 4'h0, lat, r, e);
        vecs++;
        if (r !== 32'hDEAABEEF || e !== 1'b0) begin
            errs++;
            $display("FAIL strb_rd got %h err=%b want deaabeef/0", r, e);
        end
        xact(0, 32'h13, 32'h0000_0011, 4'b0001, lat, r, e);
        xact(0, 32'h10, 32'h0, 4'h0, lat, r, e);
        vecs++;
        if (r !== 32'hDEAABE11) begin
            errs++;
            $display("FAIL strb_lane0 got %h want deaabe11", r);
        end
    endtask

    task automatic test_out_of_range;
        int lat; logic [31:0] r; logic e;
        xact(0, 32'h0, 32'hCAFEF00D, 4'hF, lat, r, e);
        xact(0, 32'h4000, 32'h12345678, 4'hF, lat, r, e);
        vecs++;
        if (lat !== 1 || e !== 1'b1 || r !== 32'h0) begin
            errs++;
            $display("FAIL oor_wr got lat=%0d err=%b rdata=%h want 1/1/0", lat, e, r);
        end
        xact(0, 32'h4000, 32'h0, 4'h0, lat, r, e);
        vecs++;
        if (lat !== 1 || e !== 1'b1 || r !== 32'h0) begin
            errs++;
            $display("FAIL oor_rd got lat=%0d err=%b rdata=%h want 1/1/0", lat, e, r);
        end
        xact(0, 32'h0, 32'h0, 4'h0, lat, r, e);
        vecs++;
        if (r !== 32'hCAFEF00D || e !== 1'b0) begin
            errs++;
            $display("FAIL oor_word0 got %h err=%b want cafef00d/0", r, e);
        end
        xact(0, 32'h3FFC, 32'h0, 4'h0, lat, r, e);
        vecs++;
        if (lat !== 1 || e !== 1'b0) begin
            errs++;
            $display("FAIL top_word got lat=%0d err=%b want 1/0", lat, e);
        end
    endtask

    task automatic test_wait;
        int lat; logic [31:0] r; logic e;
        int t0;
        int hits[$];
        logic [31:0] first_data;
        xact(3, 32'h8, 32'h0BADCAFE, 4'hF, lat, r, e);
        vecs++;
        if (lat !== 4 || e !== 1'b0 || r !== 32'h0) begin
            errs++;
            $display("FAIL w3_wr got lat=%0d err=%b rdata=%h want 4/0/0", lat, e, r);
        end
        t0 = cyc;
        first_data = 32'h0;
        drive(3, 1'b1, 32'h8, 32'h0, 4'h0);
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (rdy(3)) begin
                if (hits.size() == 0) first_data = rd(3);
                hits.push_back(cyc - t0);
            end
        end
        drive(3, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        vecs++;
        if (hits.size() != 3 || hits[0] != 4 || hits[1] != 9 || hits[2] != 14) begin
            errs++;
            $display("FAIL w3_timing got %0d pulses first=%0d want 3 at 4,9,14",
                     hits.size(), (hits.size() > 0) ? hits[0] : -1);
        end
        vecs++;
        if (first_data !== 32'h0BADCAFE) begin
            errs++;
            $display("FAIL w3_rdata got %h want 0badcafe", first_data);
        end
    endtask

    task automatic test_back_to_back(input int sel, input int gap);
        int t0;
        int hits[$];
        t0 = cyc;
        drive(sel, 1'b1, 32'h10, 32'h0, 4'h0);
        for (int k = 0; k < 100 && hits.size() < 8; k++) begin
            @(posedge clk); #1;
            if (rdy(sel)) hits.push_back(cyc - t0);
        end
        drive(sel, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rdy(sel)) hits.push_back(cyc - t0);
        end
        vecs++;
        if (hits.size() != 8) begin
            errs++;
            $display("FAIL b2b%0d_count got %0d want 8", sel, hits.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vecs++;
                if (hits[i] != gap - 1 + i * gap) begin
                    errs++;
                    $display("FAIL b2b%0d_pulse%0d got cycle %0d want %0d",
                             sel, i, hits[i], gap - 1 + i * gap);
                end
            end
        end
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] r; logic e;
        int extra;
        xact(3, 32'h20, 32'h11111111, 4'hF, lat, r, e);
        drive(3, 1'b1, 32'h20, 32'h22222222, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(3, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        vecs++;
        if (out3 !== '0 || err3 !== 1'b0) begin
            errs++;
            $display("FAIL abort_wait got %h/%b want 0/0", out3, err3);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rdy(3)) extra++;
        end
        vecs++;
        if (extra != 0) begin
            errs++;
            $display("FAIL abort_noresp got %0d pulses want 0", extra);
        end
        xact(3, 32'h20, 32'h0, 4'h0, lat, r, e);
        vecs++;
        if (lat !== 4 || r !== 32'h11111111) begin
            errs++;
            $display("FAIL abort_old got lat=%0d rdata=%h want 4/11111111", lat, r);
        end
        drive(3, 1'b1, 32'h20, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        vecs++;
        if (out3.mem_ready !== 1'b1) begin
            errs++;
            $display("FAIL resp_reach got ready=%b want 1", out3.mem_ready);
        end
        drive(3, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        rst = 1'b0;
        #1;
        vecs++;
        if (out3 !== '0 || err3 !== 1'b0) begin
            errs++;
            $display("FAIL abort_resp got %h/%b want 0/0", out3, err3);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rdy(3)) extra++;
        end
        vecs++;
        if (extra != 0) begin
            errs++;
            $display("FAIL abort_resp_quiet got %0d pulses want 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_out_of_range();
        test_wait();
        test_back_to_back(0, 2);
        test_back_to_back(3, 5);
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
